// File: rtl/time_keeper.sv
// Purpose: time-of-day keeper; loads HH:MM:SS from an ASCII frame, advances it once per second in BCD.
// Latency: accepted frame visible on digits one cycle after new_time; tick/day_wrap registered with the increment.
// Backpressure: none; new_time is a strobe and is always consumed. Optional frame validation via TIME_RANGE_CHECK_EN.

module time_keeper #(
    parameter int clk_frec = 100000000
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic [5:0][7:0] time_reg,
    input  logic            new_time,
    output logic [5:0][3:0] digits,
    output logic            valid,
    output logic            tick,
    output logic            load_err,
    output logic            day_wrap
);

    // Prescaler wide enough to hold clk_frec-1; a 1 Hz clock still needs one bit.
    localparam int PW = (clk_frec > 1) ? $clog2(clk_frec) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(clk_frec - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Digit positions inside the packed time vector.
    localparam int SEC_U  = 0;
    localparam int SEC_T  = 1;
    localparam int MIN_U  = 2;
    localparam int MIN_T  = 3;
    localparam int HOUR_U = 4;
    localparam int HOUR_T = 5;

    logic [0:0]      state;
    logic [PW-1:0]   presc;
    logic [5:0][3:0] time_q;
    logic            tick_q;
    logic            wrap_q;

    logic [5:0][3:0] load_val;
    logic            frame_ok;
    logic            load_ok;
    logic            presc_last;

    logic [5:0][3:0] inc_val;
    logic            inc_wrap;
    logic            carry;
    logic            hour_top;

    // Strip the ASCII prefix: the low nibble of a digit character is its BCD value.
    always_comb begin
        load_val = '0;
        for (int k = 0; k < 6; k++) begin
            load_val[k] = time_reg[k][3:0];
        end
    end

`ifdef TIME_RANGE_CHECK_EN
    logic err_q;

    // Frame is good only if every byte is an ASCII digit and the fields form a legal time of day.
    always_comb begin
        frame_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (time_reg[k][7:4] != 4'h3 || time_reg[k][3:0] > 4'd9) begin
                frame_ok = 1'b0;
            end
        end
        if (time_reg[HOUR_T][3:0] > 4'd2) begin
            frame_ok = 1'b0;
        end
        if (time_reg[HOUR_T][3:0] == 4'd2 && time_reg[HOUR_U][3:0] > 4'd3) begin
            frame_ok = 1'b0;
        end
        if (time_reg[MIN_T][3:0] > 4'd5) begin
            frame_ok = 1'b0;
        end
        if (time_reg[SEC_T][3:0] > 4'd5) begin
            frame_ok = 1'b0;
        end
    end

    // One-cycle error pulse for every strobed frame that fails validation.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= new_time && !frame_ok;
        end
    end

    assign load_err = err_q;
`else
    // Without validation the ASCII prefix is ignored entirely.
    logic unused_hi;
    assign unused_hi = ^{time_reg[5][7:4], time_reg[4][7:4], time_reg[3][7:4],
                         time_reg[2][7:4], time_reg[1][7:4], time_reg[0][7:4]};
    assign frame_ok  = 1'b1;
    assign load_err  = 1'b0;
`endif

    assign load_ok    = new_time && frame_ok;
    assign presc_last = (presc == PRESC_LAST);

    // Hours at or beyond 23 roll to 00; comparisons use >= so unchecked out-of-range digits still roll over.
    assign hour_top = (time_q[HOUR_T] > 4'd2) ||
                      (time_q[HOUR_T] == 4'd2 && time_q[HOUR_U] >= 4'd3);

    // One-second BCD increment with a ripple carry from seconds up to hours.
    always_comb begin
        inc_val  = time_q;
        inc_wrap = 1'b0;
        carry    = 1'b1;

        if (time_q[SEC_U] >= 4'd9) begin
            inc_val[SEC_U] = 4'd0;
        end else begin
            inc_val[SEC_U] = time_q[SEC_U] + 4'd1;
            carry          = 1'b0;
        end

        if (carry) begin
            if (time_q[SEC_T] >= 4'd5) begin
                inc_val[SEC_T] = 4'd0;
            end else begin
                inc_val[SEC_T] = time_q[SEC_T] + 4'd1;
                carry          = 1'b0;
            end
        end

        if (carry) begin
            if (time_q[MIN_U] >= 4'd9) begin
                inc_val[MIN_U] = 4'd0;
            end else begin
                inc_val[MIN_U] = time_q[MIN_U] + 4'd1;
                carry          = 1'b0;
            end
        end

        if (carry) begin
            if (time_q[MIN_T] >= 4'd5) begin
                inc_val[MIN_T] = 4'd0;
            end else begin
                inc_val[MIN_T] = time_q[MIN_T] + 4'd1;
                carry          = 1'b0;
            end
        end

        if (carry) begin
            if (hour_top) begin
                inc_val[HOUR_U] = 4'd0;
                inc_val[HOUR_T] = 4'd0;
                inc_wrap        = 1'b1;
            end else if (time_q[HOUR_U] >= 4'd9) begin
                inc_val[HOUR_U] = 4'd0;
                inc_val[HOUR_T] = time_q[HOUR_T] + 4'd1;
            end else begin
                inc_val[HOUR_U] = time_q[HOUR_U] + 4'd1;
            end
        end
    end

    // State, prescaler and time register; an accepted load takes priority over the second boundary.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state  <= IDLE;
            presc  <= '0;
            time_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (load_ok) begin
                time_q <= load_val;
                presc  <= '0;
                state  <= RUN;
            end else if (state == RUN) begin
                if (presc_last) begin
                    presc  <= '0;
                    time_q <= inc_val;
                    tick_q <= 1'b1;
                    wrap_q <= inc_wrap;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign digits   = time_q;
    assign valid    = (state == RUN);
    assign tick     = tick_q;
    assign day_wrap = wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Purpose: directed bench for time_keeper at clk_frec = 10.
// Latency: inputs driven 1 ns after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable.

module tb_time_keeper;

    logic            clk;
    logic            arstn;
    logic [5:0][7:0] time_reg;
    logic            new_time;
    logic [5:0][3:0] digits;
    logic            valid;
    logic            tick;
    logic            load_err;
    logic            day_wrap;

    int vectors;
    int miscompares;

    time_keeper #(.clk_frec(10)) dut (
        .clk      (clk),
        .arstn    (arstn),
        .time_reg (time_reg),
        .new_time (new_time),
        .digits   (digits),
        .valid    (valid),
        .tick     (tick),
        .load_err (load_err),
        .day_wrap (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting tick and day_wrap pulses seen.
    task automatic run(input int n, output int ticks, output int wraps);
        ticks = 0;
        wraps = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tick)     ticks++;
            if (day_wrap) wraps++;
        end
    endtask

    // Present a frame for exactly one cycle; on return the post-edge outputs are visible.
    task automatic send(input logic [47:0] frame);
        time_reg = frame;
        new_time = 1'b1;
        step();
        new_time = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int w;
        vectors     = 0;
        miscompares = 0;
        arstn       = 1'b0;
        new_time    = 1'b0;
        time_reg    = '0;

        // Reset state
        step();
        step();
        check("rst_digits",   digits,   32'h0);
        check("rst_valid",    valid,    32'h0);
        check("rst_tick",     tick,     32'h0);
        check("rst_load_err", load_err, 32'h0);
        check("rst_day_wrap", day_wrap, 32'h0);
        arstn = 1'b1;
        run(50, t, w);
        check("idle_ticks",  t,      32'd0);
        check("idle_wraps",  w,      32'd0);
        check("idle_digits", digits, 32'h0);
        check("idle_valid",  valid,  32'h0);

        // 12:34:56, first tick after 10 cycles
        send(48'h31_32_33_34_35_36);
        check("ld_digits", digits, 32'h123456);
        check("ld_valid",  valid,  32'h1);
        check("ld_tick",   tick,   32'h0);
        run(9, t, w);
        check("ld_pre_ticks", t, 32'd0);
        step();
        check("ld_tick1",    tick,   32'h1);
        check("ld_digits57", digits, 32'h123457);
        step();
        check("ld_tick_one_cycle", tick, 32'h0);

        // 23:59:58 -> 23:59:59 -> 00:00:00 with day_wrap on the second tick
        send(48'h32_33_35_39_35_38);
        check("dw_load", digits, 32'h235958);
        run(9, t, w);
        check("dw_pre1", t, 32'd0);
        step();
        check("dw_tick1",   tick,     32'h1);
        check("dw_digits1", digits,   32'h235959);
        check("dw_nowrap1", day_wrap, 32'h0);
        run(9, t, w);
        check("dw_pre2", t, 32'd0);
        step();
        check("dw_tick2",   tick,     32'h1);
        check("dw_wrap2",   day_wrap, 32'h1);
        check("dw_digits2", digits,   32'h000000);
        step();
        check("dw_wrap_one_cycle", day_wrap, 32'h0);

        // 01:09:59 -> 01:10:00
        send(48'h30_31_30_39_35_39);
        run(10, t, w);
        check("carry_ticks",  t,      32'd1);
        check("carry_wraps",  w,      32'd0);
        check("carry_digits", digits, 32'h011000);

        // Bad frames while running
        send(48'h31_32_33_34_35_36);
        run(3, t, w);
        send(48'h32_34_30_30_30_30);
`ifdef TIME_RANGE_CHECK_EN
        check("rej24_err",    load_err, 32'h1);
        check("rej24_digits", digits,   32'h123456);
        step();
        check("rej24_err_one_cycle", load_err, 32'h0);
        run(5, t, w);
        check("rej24_keeps_count", t,      32'd1);
        check("rej24_digits57",    digits, 32'h123457);
        send(48'h31_32_33_34_35_1E);
        check("rej1e_err",    load_err, 32'h1);
        check("rej1e_digits", digits,   32'h123457);
        // Rejected frame exactly at terminal count still lets the second elapse
        send(48'h31_32_33_34_35_36);
        run(9, t, w);
        send(48'h36_30_30_30_30_30);
        check("rejtc_err",    load_err, 32'h1);
        check("rejtc_tick",   tick,     32'h1);
        check("rejtc_digits", digits,   32'h123457);
`else
        check("nochk_digits24", digits,   32'h240000);
        check("nochk_err",      load_err, 32'h0);
        send(48'h31_32_33_34_35_1E);
        check("nochk_digits1e", digits,   32'h12345E);
        check("nochk_err1e",    load_err, 32'h0);
        // Out-of-range seconds digit still carries
        run(10, t, w);
        check("nochk_carry", digits, 32'h123500);
`endif

        // Accepted load at terminal count wins over the tick
        send(48'h31_32_33_34_35_36);
        run(9, t, w);
        send(48'h30_30_30_30_30_30);
        check("tc_digits", digits, 32'h000000);
        check("tc_tick",   tick,   32'h0);
        run(9, t, w);
        check("tc_pre_ticks", t, 32'd0);
        step();
        check("tc_tick1",   tick,   32'h1);
        check("tc_digits1", digits, 32'h000001);

        // Reset mid-count, with a frame strobed during reset
        run(4, t, w);
        arstn    = 1'b0;
        time_reg = 48'h31_32_33_34_35_36;
        new_time = 1'b1;
        step();
        new_time = 1'b0;
        check("mid_rst_digits",   digits,   32'h0);
        check("mid_rst_valid",    valid,    32'h0);
        check("mid_rst_tick",     tick,     32'h0);
        check("mid_rst_load_err", load_err, 32'h0);
        check("mid_rst_day_wrap", day_wrap, 32'h0);
        arstn = 1'b1;
        run(30, t, w);
        check("post_rst_ticks",  t,      32'd0);
        check("post_rst_valid",  valid,  32'h0);
        check("post_rst_digits", digits, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have parameter clk_frec, default 100000000, meaning clock cycles per second.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port arstn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port time_reg  input  [5:0][7:0]  received time bytes; [5] hour tens, [4] hour units, [3] min tens, [2] min units, [1] sec tens, [0] sec units; ASCII digits 0x30-0x39.
REQ-005 The block SHALL have port new_time  input  1  one-cycle strobe; time_reg valid in that cycle.
REQ-006 The block SHALL have port digits  output  [5:0][3:0]  current time as BCD, same index order as time_reg.
REQ-007 The block SHALL have port valid  output  1  high once a valid time has been loaded.
REQ-008 The block SHALL have port tick  output  1  one-cycle pulse per elapsed second.
REQ-009 The block SHALL have port load_err  output  1  one-cycle pulse when a new_time frame is rejected.
REQ-010 The block SHALL have port day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.

Function
REQ-011 States SHALL be IDLE (no valid time, no counting) and RUN (counting); IDLE -> RUN on accepted load; RUN -> IDLE only by reset.
REQ-012 On new_time in cycle N, the frame SHALL be checked combinationally and, if accepted, digits SHALL equal the low nibbles of time_reg from cycle N+1.
REQ-013 Accepted load SHALL clear the prescaler to 0, so the first tick follows clk_frec cycles after N+1.
REQ-014 Rejected frame SHALL leave digits, prescaler and state unchanged and pulse load_err in cycle N+1.
REQ-015 Prescaler SHALL count 0..clk_frec-1 in RUN only; at clk_frec-1 it SHALL wrap to 0 and tick SHALL pulse in the next cycle together with the digit increment.
REQ-016 Increment SHALL be BCD with carry: sec units 9->0 carries to sec tens; sec tens 5->0 carries to min units; min units 9->0 to min tens; min tens 5->0 to hour units; hour units 9->0 to hour tens, except 23 -> 00.
REQ-017 Increment from 23:59:59 SHALL give 00:00:00 and pulse day_wrap in the same cycle as tick.
REQ-018 new_time coinciding with prescaler terminal count SHALL load: accepted load wins, no tick, no increment; rejected frame SHALL not suppress the tick.
REQ-019 new_time during RUN SHALL reload with the same rules as from IDLE.
REQ-020 In IDLE tick and day_wrap SHALL stay 0.

Reset
REQ-021 With arstn low at a rising edge: state IDLE, prescaler 0, digits all 0, valid 0, tick 0, load_err 0, day_wrap 0.
REQ-022 Reset mid-count SHALL discard the time; the next tick requires a new accepted load.
REQ-023 new_time asserted while arstn is low SHALL be ignored.

Configuration
REQ-024 Macro TIME_RANGE_CHECK_EN SHALL select frame validation.
REQ-025 With TIME_RANGE_CHECK_EN defined: a frame SHALL be rejected if any byte is outside 0x30-0x39, hours > 23, min tens > 5 or sec tens > 5.
REQ-026 Without TIME_RANGE_CHECK_EN: every frame SHALL be accepted; low nibbles SHALL be loaded unchecked; load_err SHALL be tied 0; out-of-range digits SHALL still carry when the digit reaches or exceeds its limit (units >= 9, tens >= 5, hours >= 23).

Verification
REQ-027 The bench SHALL use clk_frec = 10 and cover these scenarios:
- Reset, then idle 50 cycles -> digits 000000, valid 0, no tick.
- Load "12:34:56" (0x31 0x32 0x33 0x34 0x35 0x36) -> digits 1,2,3,4,5,6 at N+1, valid 1, tick after 10 cycles, digits 12:34:57.
- Load "23:59:58", run 20 cycles -> 23:59:59 then 00:00:00 with day_wrap coinciding with second tick.
- Load "01:09:59", one tick -> 01:10:00.
- With TIME_RANGE_CHECK_EN, while running 12:34:56 send 0x32 0x34 0x30 0x30 0x30 0x30 ("24:00:00") -> load_err one cycle, time keeps counting; send byte 0x1E -> load_err.
- new_time at prescaler terminal count with valid frame "00:00:00" -> digits 000000, no tick that cycle; assert arstn low mid-count -> all outputs 0, IDLE.
